mem_sweep_sequencer: RTL and testbench



---
 rtl/mem_sweep_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_sweep_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sweep_sequencer.sv
// Memory-exercise master for the BRAM valid/ready bus. It sweeps NUM_WORDS words, mirrors
// the read data on the LEDs, dwells per word, and can optionally fill memory with a pattern and verify it.
module mem_sweep_sequencer #(
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
    parameter int unsigned NUM_WORDS      = 2,
    parameter logic [31:0] STRIDE         = 32'd4,
    parameter int unsigned DWELL_CYCLES   = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned LED_W          = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         mode,
    output logic                         mem_valid,
    input  logic                         mem_ready,
    output logic [31:0]                  mem_addr,
    output logic [31:0]                  mem_wdata,
    output logic [3:0]                   mem_wstrb,
    input  logic [31:0]                  mem_rdata,
    output logic [LED_W-1:0]             led,
    output logic                         busy,
    output logic [$clog2(NUM_WORDS):0]   index,
    output logic [15:0]                  err_count,
    output logic                         timeout
);

    localparam int unsigned IDX_W  = $clog2(NUM_WORDS) + 1;
    localparam int unsigned DCNT_W = $clog2(DWELL_CYCLES + 1);
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_WORDS - 1);
    localparam logic [DCNT_W-1:0] DWELL_LAST = DCNT_W'(DWELL_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TOUT_LAST  = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]       PAT_KEY    = 32'hA5A5_A5A5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DWELL = 2'd3
    } state_t;

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return a ^ PAT_KEY;
    endfunction

    function automatic logic [31:0] addr_of(input logic [IDX_W-1:0] idx);
        logic [31:0] idx32;
        idx32            = 32'd0;
        idx32[IDX_W-1:0] = idx;
        return ADDR_BASE + idx32 * STRIDE;
    endfunction

    function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx);
        return (idx == IDX_LAST) ? {IDX_W{1'b0}} : idx + IDX_W'(1);
    endfunction

    state_t              state_q,   state_d;
    logic                valid_q,   valid_d;
    logic [31:0]         addr_q,    addr_d;
    logic [31:0]         wdata_q,   wdata_d;
    logic [3:0]          wstrb_q,   wstrb_d;
    logic [LED_W-1:0]    led_q,     led_d;
    logic                busy_q,    busy_d;
    logic [IDX_W-1:0]    index_q,   index_d;
    logic [15:0]         err_count_q, err_count_d;
    logic                timeout_q, timeout_d;
    logic                mode_q,    mode_d;
    logic                stop_pend_q, stop_pend_d;
    logic [DCNT_W-1:0]   dwell_q,   dwell_d;
    logic [TCNT_W-1:0]   wait_q,    wait_d;
    logic                stop_now_s;
    logic [31:0]         req_addr_s;

    assign req_addr_s = addr_of(index_q);

    // Next-state and output-register logic for the sweep FSM.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        led_d       = led_q;
        index_d     = index_q;
        err_count_d = err_count_q;
        timeout_d   = timeout_q;
        mode_d      = mode_q;
        stop_pend_d = stop_pend_q;
        dwell_d     = dwell_q;
        wait_d      = wait_q;
        stop_now_s  = stop_pend_q | stop;

        case (state_q)
            IDLE: begin
                stop_pend_d = 1'b0;
                if (start && !stop) begin
                    mode_d      = mode;
                    err_count_d = 16'd0;
                    timeout_d   = 1'b0;
                    index_d     = {IDX_W{1'b0}};
                    state_d     = mode ? WRITE : READ;
                end else begin
                    state_d = IDLE;
                end
            end

            WRITE, READ: begin
                if (!valid_q) begin
                    // No transaction in flight yet, so a stop here abandons nothing.
                    if (stop_now_s) begin
                        state_d     = IDLE;
                        stop_pend_d = 1'b0;
                    end else begin
                        valid_d = 1'b1;
                        addr_d  = req_addr_s;
                        wait_d  = {TCNT_W{1'b0}};
                        if (state_q == WRITE) begin
                            wstrb_d = 4'hF;
                            wdata_d = pattern(req_addr_s);
                        end else begin
                            wstrb_d = 4'h0;
                            wdata_d = 32'd0;
                        end
                    end
                end else if (mem_ready) begin
                    valid_d     = 1'b0;
                    stop_pend_d = 1'b0;
                    if (state_q == WRITE) begin
                        index_d = next_index(index_q);
                        if (stop_now_s) begin
                            state_d = IDLE;
                        end else if (index_q == IDX_LAST) begin
                            state_d = READ;
                        end else begin
                            state_d = WRITE;
                        end
                    end else begin
                        led_d   = mem_rdata[LED_W-1:0];
                        dwell_d = {DCNT_W{1'b0}};
                        if (mode_q && (mem_rdata != pattern(addr_q)) && (err_count_q != 16'hFFFF)) begin
                            err_count_d = err_count_q + 16'd1;
                        end else begin
                            err_count_d = err_count_q;
                        end
                        state_d = stop_now_s ? IDLE : DWELL;
                    end
                end else if (wait_q == TOUT_LAST) begin
                    valid_d     = 1'b0;
                    timeout_d   = 1'b1;
                    stop_pend_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    wait_d      = wait_q + TCNT_W'(1);
                    stop_pend_d = stop_now_s;
                end
            end

            DWELL: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (dwell_q == DWELL_LAST) begin
                    index_d = next_index(index_q);
                    state_d = READ;
                end else begin
                    dwell_d = dwell_q + DCNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered-output flops; reset acts immediately, even mid-transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            addr_q      <= ADDR_BASE;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'h0;
            led_q       <= {LED_W{1'b0}};
            busy_q      <= 1'b0;
            index_q     <= {IDX_W{1'b0}};
            err_count_q <= 16'd0;
            timeout_q   <= 1'b0;
            mode_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            dwell_q     <= {DCNT_W{1'b0}};
            wait_q      <= {TCNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
            index_q     <= index_d;
            err_count_q <= err_count_d;
            timeout_q   <= timeout_d;
            mode_q      <= mode_d;
            stop_pend_q <= stop_pend_d;
            dwell_q     <= dwell_d;
            wait_q      <= wait_d;
        end
    end

    assign mem_valid = valid_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign led       = led_q;
    assign busy      = busy_q;
    assign index     = index_q;
    assign err_count = err_count_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_mem_sweep_sequencer.sv
// Directed bench for mem_sweep_sequencer: a small bus memory with programmable ready latency,
// a request log, and hand-computed expectations checked by immediate assertions.
module tb_mem_sweep_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mode = 1'b0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'd0;
    logic [7:0]  led;
    logic        busy;
    logic [2:0]  index;
    logic [15:0] err_count;
    logic        timeout;

    mem_sweep_sequencer #(
        .ADDR_BASE(32'h0000_0100), .NUM_WORDS(4), .STRIDE(32'd4),
        .DWELL_CYCLES(8), .TIMEOUT_CYCLES(16), .LED_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .mode(mode),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .led(led), .busy(busy), .index(index), .err_count(err_count), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Memory model controls, driven from the main sequence.
    logic resp_en    = 1'b1;
    logic use_rom    = 1'b0;
    logic corrupt_en = 1'b0;
    int   lat        = 1;

    logic [31:0] rom [4] = '{32'hDEAD_BE11, 32'hDEAD_BE22, 32'hDEAD_BE33, 32'hDEAD_BE44};
    logic [31:0] mem [4];
    int          vcnt     = 0;
    int          last_run = 0;
    logic [1:0]  widx_s;

    logic [31:0] q_addr[$];
    logic [31:0] q_wdata[$];
    logic [3:0]  q_wstrb[$];
    logic [7:0]  q_led[$];
    logic [2:0]  q_idx[$];
    int          q_cyc[$];

    assign widx_s = mem_addr[3:2];

    always @(posedge clk) cyc <= cyc + 1;

    // Bus responder and request logger; ready arrives after lat+1 valid cycles.
    always @(negedge clk) begin
        if (!reset_n) begin
            mem_ready <= 1'b0;
            vcnt      <= 0;
        end else if (mem_valid && !mem_ready) begin
            vcnt <= vcnt + 1;
            if (vcnt == 0) begin
                q_addr.push_back(mem_addr);
                q_wdata.push_back(mem_wdata);
                q_wstrb.push_back(mem_wstrb);
                q_led.push_back(led);
                q_idx.push_back(index);
                q_cyc.push_back(cyc);
            end
            if (resp_en && vcnt >= lat) begin
                mem_ready <= 1'b1;
                if (mem_wstrb != 4'h0) mem[widx_s] <= mem_wdata;
                else if (use_rom) mem_rdata <= rom[widx_s];
                else mem_rdata <= mem[widx_s] ^ ((corrupt_en && widx_s == 2'd2) ? 32'h1 : 32'h0);
            end
        end else begin
            if (vcnt != 0) last_run <= vcnt;
            mem_ready <= 1'b0;
            vcnt      <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample/drive point well away from both clock edges.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input logic m);
        step();
        start = 1'b1;
        mode  = m;
        step();
        start = 1'b0;
    endtask

    task automatic wait_reqs(input string tag, input int n, input int budget);
        int k = 0;
        while (q_addr.size() < n && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(q_addr.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 32'(mem_valid), 32'd0);
        check({tag, "_addr"},  mem_addr, 32'h0000_0100);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_wstrb"}, 32'(mem_wstrb), 32'd0);
        check({tag, "_led"},   32'(led), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_index"}, 32'(index), 32'd0);
        check({tag, "_err"},   32'(err_count), 32'd0);
        check({tag, "_tmo"},   32'(timeout), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        int k;
        logic [7:0]  led_exp [6] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        logic [31:0] wd_exp  [4] = '{32'hA5A5_A4A5, 32'hA5A5_A4A1, 32'hA5A5_A4AD, 32'hA5A5_A4A9};

        // Reset state.
        repeat (3) step();
        check_reset_values("rst");
        reset_n = 1'b1;

        // Read-only sweep from a preloaded ROM, ready latency 1.
        use_rom = 1'b1;
        b = q_addr.size();
        pulse_start(1'b0);
        check("ro_busy", 32'(busy), 32'd1);
        wait_reqs("ro_reqs", b + 6, 200);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("ro_addr%0d", i),  q_addr[b+i], 32'h100 + 32'(4 * (i % 4)));
            check($sformatf("ro_wstrb%0d", i), 32'(q_wstrb[b+i]), 32'd0);
            check($sformatf("ro_idx%0d", i),   32'(q_idx[b+i]), 32'(i % 4));
            check($sformatf("ro_led%0d", i),   32'(q_led[b+i]), 32'(led_exp[i]));
            if (i > 0) check($sformatf("ro_gap%0d", i), 32'(q_cyc[b+i] - q_cyc[b+i-1]), 32'd11);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle("ro_stop_idle", 50);

        // Write pass then verify sweeps against an ideal memory; mode changes while busy are ignored.
        use_rom = 1'b0;
        b = q_addr.size();
        pulse_start(1'b1);
        mode = 1'b0;
        check("wv_tmo_clr", 32'(timeout), 32'd0);
        wait_reqs("wv_reqs", b + 13, 300);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wv_waddr%0d", i), q_addr[b+i], 32'h100 + 32'(4 * i));
            check($sformatf("wv_wdata%0d", i), q_wdata[b+i], wd_exp[i]);
            check($sformatf("wv_wstrb%0d", i), 32'(q_wstrb[b+i]), 32'hF);
            check($sformatf("wv_wgap%0d", i),  32'(q_cyc[b+i+1] - q_cyc[b+i]), 32'd3);
        end
        check("wv_raddr",  q_addr[b+4], 32'h100);
        check("wv_rwstrb", 32'(q_wstrb[b+4]), 32'd0);
        check("wv_rwdata", q_wdata[b+4], 32'd0);
        check("wv_mem2",   mem[2], 32'hA5A5_A4AD);
        check("wv_err0",   32'(err_count), 32'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle("wv_idle", 50);

        // Word 2 corrupted on readback: one mismatch per sweep, then saturation.
        corrupt_en = 1'b1;
        b = q_addr.size();
        pulse_start(1'b1);
        mode = 1'b0;
        wait_reqs("cr_reqs", b + 13, 300);
        check("cr_err2", 32'(err_count), 32'd2);
        force dut.err_count_q = 16'hFFFE;
        step();
        step();
        release dut.err_count_q;
        wait_reqs("cr_reqs_sat", b + 25, 300);
        check("cr_err_sat", 32'(err_count), 32'hFFFF);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle("cr_idle", 50);
        check("cr_err_hold", 32'(err_count), 32'hFFFF);
        corrupt_en = 1'b0;

        // Stop during a read whose ready is delayed.
        lat = 5;
        b = q_addr.size();
        pulse_start(1'b0);
        k = 0;
        while (!mem_valid && k < 10) begin step(); k++; end
        check("sp_valid_up", 32'(mem_valid), 32'd1);
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        k = 0;
        while (!mem_ready && k < 20) begin step(); k++; end
        check("sp_ready_seen", 32'(mem_ready), 32'd1);
        check("sp_busy",  32'(busy), 32'd0);
        check("sp_valid", 32'(mem_valid), 32'd0);
        check("sp_led",   32'(led), 32'hA5);
        step();
        check("sp_run", 32'(last_run), 32'd6);
        check("sp_nreq", 32'(q_addr.size() - b), 32'd1);

        // start and stop together in IDLE.
        b = q_addr.size();
        step();
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        repeat (5) step();
        check("ss_busy", 32'(busy), 32'd0);
        check("ss_nreq", 32'(q_addr.size() - b), 32'd0);

        // Bus timeout with ready never asserted.
        lat     = 1;
        resp_en = 1'b0;
        pulse_start(1'b0);
        wait_idle("to_idle", 100);
        check("to_flag",  32'(timeout), 32'd1);
        check("to_valid", 32'(mem_valid), 32'd0);
        step();
        check("to_run", 32'(last_run), 32'd16);
        pulse_start(1'b0);
        check("to_clr",  32'(timeout), 32'd0);
        check("to_busy", 32'(busy), 32'd1);

        // Asynchronous reset while a request is pending.
        k = 0;
        while (!mem_valid && k < 10) begin step(); k++; end
        check("ar_valid_up", 32'(mem_valid), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_values("ar");
        step();
        reset_n = 1'b1;
        resp_en = 1'b1;
        b = q_addr.size();
        repeat (20) step();
        check("ar_nreq",  32'(q_addr.size() - b), 32'd0);
        check("ar_busy",  32'(busy), 32'd0);
        check("ar_valid", 32'(mem_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
